// File: rtl/btn_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_sched_pkg                                                        |
// | Shared types, requester-to-operation map and LD operation helper.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package btn_sched_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    OP_INC = 2'd0,
    OP_DEC = 2'd1,
    OP_ROL = 2'd2,
    OP_ROR = 2'd3
  } op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam op_e REQ_OP [N_REQ] = '{OP_INC, OP_DEC, OP_ROL, OP_ROR};

  function automatic logic [7:0] apply_op(input op_e op, input logic [7:0] v);
    logic [7:0] r;
    r = v;
    case (op)
      OP_INC:  r = v + 8'd1;
      OP_DEC:  r = v - 8'd1;
      OP_ROL:  r = {v[6:0], v[7]};
      OP_ROR:  r = {v[0], v[7:1]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick, searching upward from ptr+1.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
  import btn_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [1:0]       idx_o
);

  logic [1:0] w_cand;

  // Walk from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    gnt_o  = '0;
    idx_o  = '0;
    w_cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = ptr_i + 2'(k);
      if (req_i[w_cand]) begin
        gnt_o         = '0;
        gnt_o[w_cand] = 1'b1;
        idx_o         = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_event_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_event_sched                                                      |
// | Round-robin scheduler sharing the LD register among four requesters. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_event_sched
  import btn_sched_pkg::*;
#(
  parameter int PEND_W      = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       GCLK,
  input  logic       BTNC,
  input  logic [3:0] req_tick,
  output logic [7:0] LD,
  output logic [3:0] grant,
  output logic       busy,
  output logic [3:0] pend_nz,
  output logic [3:0] ovf
);

  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [7:0]        HOLD_INIT = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

  logic [PEND_W-1:0] pend_q [N_REQ];
  logic [N_REQ-1:0]  ovf_q;
  state_e            state_q, state_d;
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        ld_q, ld_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              busy_q;

  logic [N_REQ-1:0]  w_req;
  logic [N_REQ-1:0]  w_win_oh;
  logic [1:0]        w_win_idx;
  logic              w_fire;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_req[i] = (pend_q[i] != '0);
    end
  end

  rr_arbiter u_arb (
    .req_i (w_req),
    .ptr_i (ptr_q),
    .gnt_o (w_win_oh),
    .idx_o (w_win_idx)
  );

  assign w_fire = (state_q == IDLE) && (|w_req);

  always_ff @(posedge GCLK or posedge BTNC) begin
    if (BTNC) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ld_q    <= '0;
      grant_q <= '0;
      ptr_q   <= 2'd3;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ld_q    <= ld_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      busy_q  <= (state_q == HOLD);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (w_fire && (HOLD_CYCLES != 0)) begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      HOLD: begin
        if (hold_q == 8'd0) state_d = IDLE;
        else                hold_d  = hold_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = '0;
    ld_d    = ld_q;
    ptr_d   = ptr_q;
    if (w_fire) begin
      grant_d = w_win_oh;
      ld_d    = apply_op(REQ_OP[w_win_idx], ld_q);
      ptr_d   = w_win_idx;
    end
  end

  // A tick and a grant on the same edge cancel; a tick at saturation is lost.
  always_ff @(posedge GCLK or posedge BTNC) begin
    if (BTNC) begin
      for (int i = 0; i < N_REQ; i++) pend_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_tick[i] && !grant_d[i]) begin
          if (pend_q[i] == PEND_MAX) ovf_q[i]  <= 1'b1;
          else                       pend_q[i] <= pend_q[i] + 1'b1;
        end else if (!req_tick[i] && grant_d[i]) begin
          pend_q[i] <= pend_q[i] - 1'b1;
        end
      end
    end
  end

  assign LD      = ld_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign pend_nz = w_req;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_btn_event_sched                                                   |
// | Directed scoreboard bench for the round-robin LD scheduler.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_btn_event_sched;

  logic       GCLK = 1'b0;
  logic       BTNC = 1'b0;
  logic [3:0] req_tick = '0;
  logic [7:0] LD;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] pend_nz;
  logic [3:0] ovf;

  btn_event_sched #(.PEND_W(3), .HOLD_CYCLES(4)) dut (
    .GCLK     (GCLK),
    .BTNC     (BTNC),
    .req_tick (req_tick),
    .LD       (LD),
    .grant    (grant),
    .busy     (busy),
    .pend_nz  (pend_nz),
    .ovf      (ovf)
  );

  always #5 GCLK = ~GCLK;

  int cyc = 0;
  always @(posedge GCLK) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [7:0] ld;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] ld_model = '0;
  int         n_chk  = 0;
  int         n_fail = 0;
  int         seq = 0;
  int         last_seq = -1;
  int         last_cyc = 0;

  function automatic logic [7:0] op_ref(input int i, input logic [7:0] v);
    case (i)
      0:       return v + 8'd1;
      1:       return v - 8'd1;
      2:       return {v[6:0], v[7]};
      default: return {v[0], v[7:1]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge GCLK);
    #1;
  endtask

  task automatic expect_grant(input int i);
    ld_model = op_ref(i, ld_model);
    exp_q.push_back('{idx: i, ld: ld_model});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (6) step();
  endtask

  task automatic do_op(input int i, input logic [7:0] ld_exp);
    seq++;
    expect_grant(i);
    req_tick = 4'(1 << i);
    step();
    req_tick = '0;
    drain();
    chk("ld_after_op", 32'(LD), 32'(ld_exp));
  endtask

  task automatic pulse_reset();
    BTNC = 1'b1;
    #1;
    ld_model = '0;
    repeat (2) step();
    BTNC = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge GCLK);
        if (!BTNC && grant !== 4'b0000) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 32'(grant), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("grant_onehot", 32'(grant), 32'(1 << e.idx));
            chk("grant_ld", 32'(LD), 32'(e.ld));
            if (seq == last_seq) chk("grant_gap", 32'(cyc - last_cyc), 32'd5);
            last_seq = seq;
            last_cyc = cyc;
          end
        end
      end
    join_none

    #1 BTNC = 1'b1;
    #1;
    chk("rst_ld", 32'(LD), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pend_nz", 32'(pend_nz), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) step();
    BTNC = 1'b0;
    repeat (2) step();

    // Single tick: latency and busy window
    seq++;
    expect_grant(0);
    req_tick = 4'b0001;
    step();
    req_tick = '0;
    chk("t1_pend_nz", 32'(pend_nz), 32'h1);
    chk("t1_no_grant_yet", 32'(grant), 32'h0);
    step();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_ld", 32'(LD), 32'h01);
    chk("t1_busy_grant_cycle", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_busy_high", 32'(busy), 32'd1);
    end
    step();
    chk("t1_busy_low", 32'(busy), 32'd0);
    repeat (2) step();

    // Four simultaneous ticks from reset state
    pulse_reset();
    seq++;
    for (int i = 0; i < 4; i++) expect_grant(i);
    req_tick = 4'b1111;
    step();
    req_tick = '0;
    chk("t2_pend_nz_all", 32'(pend_nz), 32'hF);
    drain();
    chk("t2_pend_nz_empty", 32'(pend_nz), 32'h0);
    chk("t2_ld", 32'(LD), 32'h00);

    // Individual operations
    do_op(1, 8'hFF);
    do_op(0, 8'h00);
    do_op(0, 8'h01);
    do_op(3, 8'h80);
    do_op(0, 8'h81);
    do_op(2, 8'h03);
    do_op(3, 8'h81);
    do_op(3, 8'hC0);

    // Saturation on requester 0 while another grant holds the register
    seq++;
    expect_grant(3);
    for (int k = 0; k < 8; k++) expect_grant(0);
    req_tick = 4'b1000;
    step();
    for (int k = 1; k <= 9; k++) begin
      req_tick = 4'b0001;
      step();
      if (k == 8) chk("t4_ovf_before", 32'(ovf), 32'h0);
    end
    req_tick = '0;
    chk("t4_ovf_set", 32'(ovf), 32'h1);
    chk("t4_pend_nz", 32'(pend_nz), 32'h1);
    drain();
    chk("t4_pend_nz_empty", 32'(pend_nz), 32'h0);
    chk("t4_ovf_sticky", 32'(ovf), 32'h1);

    // Tick coinciding with own grant
    seq++;
    expect_grant(1);
    expect_grant(1);
    req_tick = 4'b0010;
    step();
    step();
    req_tick = '0;
    chk("t5_grant", 32'(grant), 32'h2);
    chk("t5_pend_kept", 32'(pend_nz), 32'h2);
    drain();
    chk("t5_pend_nz_empty", 32'(pend_nz), 32'h0);

    // Reset in HOLD with pending 3/2/0/1
    seq++;
    expect_grant(3);
    req_tick = 4'b1011;
    step();
    step();
    req_tick = 4'b0001;
    step();
    req_tick = '0;
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_pend_nz", 32'(pend_nz), 32'hB);
    BTNC = 1'b1;
    #1;
    chk("t6_rst_ld", 32'(LD), 32'd0);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_pend_nz", 32'(pend_nz), 32'd0);
    chk("t6_rst_ovf", 32'(ovf), 32'd0);
    chk("t6_queue_before_rst", 32'(exp_q.size()), 32'd0);
    ld_model = '0;
    repeat (3) step();
    BTNC = 1'b0;
    seq++;
    repeat (10) step();
    chk("t6_idle_pend", 32'(pend_nz), 32'h0);
    chk("t6_idle_ld", 32'(LD), 32'h00);
    for (int i = 0; i < 4; i++) expect_grant(i);
    req_tick = 4'b1111;
    step();
    req_tick = '0;
    drain();
    chk("t6_final_ld", 32'(LD), 32'h00);
    chk("t6_final_pend", 32'(pend_nz), 32'h0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
